bcdc_run_ctrl: RTL and testbench

//  Sequencer for the two-digit BCD up-counter (00..99). Issues the counter's EN as

---
 rtl/bcdc_pkg.sv | 47 ++++
 rtl/bcdc_run_ctrl_presc.sv | 43 ++++
 rtl/bcdc_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_bcdc_run_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcdc_pkg.sv
// -----------------------------------------------------------------------------
// bcdc_pkg
// Shared definitions for the BCD counter run controller:
//   - state encodings (IDLE/RUN/STEP/DONE)
//   - BCD_MAX, the last value before the counter rolls over
//   - bcd_inc   : two-digit BCD increment, 99 rolls to 00
//   - bcd_valid : 1 when both nibbles are decimal digits
// -----------------------------------------------------------------------------
package bcdc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Plain vector forms of the state encodings, used for the state flops.
  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(S_RUN);
  localparam logic [1:0] ST_STEP = 2'(S_STEP);
  localparam logic [1:0] ST_DONE = 2'(S_DONE);

  localparam logic [7:0] BCD_MAX = 8'h99;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] units;
    logic [3:0] tens;
    units = v[3:0];
    tens  = v[7:4];
    if (v == BCD_MAX) begin
      return 8'h00;
    end
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcdc_run_ctrl_presc.sv
// -----------------------------------------------------------------------------
// bcdc_presc
// Prescaler down-counter for the run controller.
//   ck, rn    : clock / async active-low reset (counter clears to 0)
//   load      : load load_val (has priority over tick)
//   tick      : decrement by one (holds at 0)
//   load_val  : reload value
//   zero      : 1 when the counter is 0
// -----------------------------------------------------------------------------
module bcdc_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               ck,
  input  logic               rn,
  input  logic               load,
  input  logic               tick,
  input  logic [PRESC_W-1:0] load_val,
  output logic               zero
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bcdc_run_ctrl.sv
// -----------------------------------------------------------------------------
// bcdc_run_ctrl
// Sequencer for a two-digit BCD up-counter (00..99). Issues the counter's
// enable as single-cycle prescaled pulses under start/stop/step commands and
// stops automatically when the count reaches a programmed BCD target.
//
// Ports:
//   CK, RN            clock / async active-low reset (shared with the counter)
//   cmd_start/stop/step  command pulses (priority stop > start > step)
//   match_en          level, enables auto-stop on target match
//   tgt_wr, tgt_data  target write (non-BCD data is ignored)
//   presc_wr, presc_data  prescaler reload write (used at the next reload)
//   cnt_q             counter value {tens,units} read back
//   cnt_en            registered enable pulse to the counter
//   busy              1 in RUN or STEP
//   state_o           current state encoding
//   match_irq         1-cycle pulse aligned with the matching cnt_en
//   wrap_flag         sticky, counter rolled 99->00 since the last start
//
// Build option BCDC_RUN_CTRL_SYNC_EN: when defined, the three command inputs
// go through 2-flop synchronisers and a registered rising-edge detector so
// they can be asynchronous levels (3 cycles of extra latency). When not
// defined, commands are synchronous 1-cycle pulses used directly.
// -----------------------------------------------------------------------------
module bcdc_run_ctrl
  import bcdc_pkg::*;
#(
  parameter int                 PRESC_W       = 16,
  parameter logic [PRESC_W-1:0] PRESC_DEFAULT = '0
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cmd_step,
  input  logic               match_en,
  input  logic               tgt_wr,
  input  logic [7:0]         tgt_data,
  input  logic               presc_wr,
  input  logic [PRESC_W-1:0] presc_data,
  input  logic [7:0]         cnt_q,
  output logic               cnt_en,
  output logic               busy,
  output logic [1:0]         state_o,
  output logic               match_irq,
  output logic               wrap_flag
);

  logic do_start;
  logic do_stop;
  logic do_step;

`ifdef BCDC_RUN_CTRL_SYNC_EN
  // Bit order {step, start, stop}.
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] prev_q,  prev_d;
  logic [2:0] cmd_q,   cmd_d;

  always_comb begin
    sync1_d = {cmd_step, cmd_start, cmd_stop};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cmd_d   = sync2_q & ~prev_q;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cmd_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cmd_q   <= cmd_d;
    end
  end

  assign {do_step, do_start, do_stop} = cmd_q;
`else
  assign do_start = cmd_start;
  assign do_stop  = cmd_stop;
  assign do_step  = cmd_step;
`endif

  logic [1:0]         state_q, state_d;
  logic               cnt_en_q, cnt_en_d;
  logic               match_irq_q, match_irq_d;
  logic               wrap_q, wrap_d;
  logic [7:0]         tgt_q, tgt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;

  logic       presc_zero;
  logic       presc_load;
  logic       presc_tick;
  logic       issue;
  logic       can_cmd;
  logic [7:0] base;
  logic [7:0] nxt;

  bcdc_presc #(.PRESC_W(PRESC_W)) u_presc (
    .ck       (CK),
    .rn       (RN),
    .load     (presc_load),
    .tick     (presc_tick),
    .load_val (presc_q),
    .zero     (presc_zero)
  );

  always_comb begin
    // A pulse still in flight has not reached cnt_q yet; fold it in so the
    // prediction stays exact when pulses run back to back.
    base = cnt_en_q ? bcd_inc(cnt_q) : cnt_q;
    nxt  = bcd_inc(base);

    can_cmd     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    state_d     = state_q;
    issue       = 1'b0;
    presc_load  = 1'b0;
    presc_tick  = 1'b0;
    wrap_d      = wrap_q;
    cnt_en_d    = 1'b0;
    match_irq_d = 1'b0;

    if (do_stop) begin
      state_d = ST_IDLE;
    end else if (do_start && can_cmd) begin
      state_d    = ST_RUN;
      presc_load = 1'b1;
      wrap_d     = 1'b0;
    end else if (do_step && can_cmd) begin
      state_d = ST_STEP;
    end else if (state_q == ST_RUN) begin
      if (presc_zero) begin
        issue      = 1'b1;
        presc_load = 1'b1;
      end else begin
        presc_tick = 1'b1;
      end
    end else if (state_q == ST_STEP) begin
      issue   = 1'b1;
      state_d = ST_IDLE;
    end

    if (issue) begin
      cnt_en_d = 1'b1;
      if (base == BCD_MAX) begin
        wrap_d = 1'b1;
      end
      // Compares against the target held before any same-cycle write.
      if (match_en && (nxt == tgt_q)) begin
        match_irq_d = 1'b1;
        state_d     = ST_DONE;
      end
    end

    tgt_d   = (tgt_wr && bcd_valid(tgt_data)) ? tgt_data : tgt_q;
    presc_d = presc_wr ? presc_data : presc_q;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      cnt_en_q    <= 1'b0;
      match_irq_q <= 1'b0;
      wrap_q      <= 1'b0;
      tgt_q       <= BCD_MAX;
      presc_q     <= PRESC_DEFAULT;
    end else begin
      state_q     <= state_d;
      cnt_en_q    <= cnt_en_d;
      match_irq_q <= match_irq_d;
      wrap_q      <= wrap_d;
      tgt_q       <= tgt_d;
      presc_q     <= presc_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign match_irq = match_irq_q;
  assign wrap_flag = wrap_q;
  assign state_o   = state_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_STEP);

endmodule

// File: tb/tb_bcdc_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcdc_run_ctrl
// Directed plus randomized stimulus for bcdc_run_ctrl (default build). A
// behavioural BCD counter is attached to cnt_en/cnt_q. The reference model
// tracks the counter as a decimal number of issued pulses and compares the
// controller outputs every cycle.
// -----------------------------------------------------------------------------
module tb_bcdc_run_ctrl;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_stop  = 1'b0;
  logic        cmd_step  = 1'b0;
  logic        match_en  = 1'b0;
  logic        tgt_wr    = 1'b0;
  logic [7:0]  tgt_data  = 8'h00;
  logic        presc_wr  = 1'b0;
  logic [15:0] presc_data = 16'h0000;
  logic [7:0]  cnt_q;
  logic        cnt_en;
  logic        busy;
  logic [1:0]  state_o;
  logic        match_irq;
  logic        wrap_flag;

  int n_err = 0;
  int n_chk = 0;

  always #5 CK = ~CK;

  bcdc_run_ctrl dut (
    .CK         (CK),
    .RN         (RN),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .cmd_step   (cmd_step),
    .match_en   (match_en),
    .tgt_wr     (tgt_wr),
    .tgt_data   (tgt_data),
    .presc_wr   (presc_wr),
    .presc_data (presc_data),
    .cnt_q      (cnt_q),
    .cnt_en     (cnt_en),
    .busy       (busy),
    .state_o    (state_o),
    .match_irq  (match_irq),
    .wrap_flag  (wrap_flag)
  );

  // Behavioural two-digit BCD counter driven by the controller.
  int cnt_dec = 0;
  always @(posedge CK or negedge RN) begin
    if (!RN) cnt_dec <= 0;
    else if (cnt_en) cnt_dec <= (cnt_dec + 1) % 100;
  end
  assign cnt_q = {4'(cnt_dec / 10), 4'(cnt_dec % 10)};

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference model: 0=IDLE 1=RUN 2=STEP 3=DONE.
  int         m_state;
  int         m_cd;
  int         m_presc;
  int         m_val;      // counter value once every issued pulse has landed
  logic [7:0] m_tgt;
  logic       m_en, m_irq, m_wrap;

  task automatic model_reset();
    m_state = 0; m_cd = 0; m_presc = 0; m_val = 0; m_tgt = 8'h99;
    m_en = 1'b0; m_irq = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step();
    int  ns;
    bit  fire;
    bit  idle_like;
    ns = m_state; fire = 0; m_en = 1'b0; m_irq = 1'b0;
    idle_like = (m_state == 0) || (m_state == 3);
    if (cmd_stop) ns = 0;
    else if (cmd_start && idle_like) begin ns = 1; m_cd = m_presc; m_wrap = 1'b0; end
    else if (cmd_step && idle_like) ns = 2;
    else if (m_state == 1) begin
      if (m_cd == 0) begin fire = 1; m_cd = m_presc; end
      else m_cd = m_cd - 1;
    end else if (m_state == 2) begin fire = 1; ns = 0; end
    if (fire) begin
      m_en = 1'b1;
      if (m_val == 99) m_wrap = 1'b1;
      m_val = (m_val + 1) % 100;
      if (match_en && to_bcd(m_val) == m_tgt) begin m_irq = 1'b1; ns = 3; end
    end
    m_state = ns;
    if (tgt_wr && tgt_data[3:0] <= 4'd9 && tgt_data[7:4] <= 4'd9) m_tgt = tgt_data;
    if (presc_wr) m_presc = int'(presc_data);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("cnt_en",    32'(cnt_en),    32'(m_en));
    chk("match_irq", 32'(match_irq), 32'(m_irq));
    chk("wrap_flag", 32'(wrap_flag), 32'(m_wrap));
    chk("state_o",   32'(state_o),   32'(m_state));
    chk("busy",      32'(busy),      32'((m_state == 1) || (m_state == 2)));
  endtask

  // One clock: model consumes current inputs, DUT samples them at the edge,
  // outputs are compared 1 time unit later, then strobes are dropped.
  task automatic tick();
    model_step();
    @(posedge CK);
    #1;
    chk_outputs();
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    tgt_wr = 1'b0; presc_wr = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (cnt_en !== 1'b1 && n < 500);
    chk({tag, "_timeout"}, 32'(n < 500), 32'd1);
  endtask

  task automatic do_reset();
    #1;
    RN = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    tgt_wr = 1'b0; presc_wr = 1'b0;
    #1;
    model_reset();
    chk("rst_cnt_en",    32'(cnt_en),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_state",     32'(state_o),   32'd0);
    chk("rst_match_irq", 32'(match_irq), 32'd0);
    chk("rst_wrap",      32'(wrap_flag), 32'd0);
    chk("rst_cnt_q",     32'(cnt_q),     32'h00);
    @(negedge CK);
    RN = 1'b1;
  endtask

  initial begin
    int n;
    int pulses;
    bit irq5;

    // ---- T1: 5 back-to-back pulses, match on the 5th ----
    do_reset();
    tgt_wr = 1'b1; tgt_data = 8'h05; match_en = 1'b1;
    tick();
    cmd_start = 1'b1;
    tick();
    pulses = 0; irq5 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cnt_en === 1'b1) pulses++;
      if (i == 4) irq5 = match_irq;
    end
    chk("t1_pulses", 32'(pulses), 32'd5);
    chk("t1_irq5", 32'(irq5), 32'd1);
    chk("t1_state_done", 32'(state_o), 32'd3);
    tick();
    chk("t1_cnt_q", 32'(cnt_q), 32'h05);
    $display("T1 match at target 05: pulses=%0d cnt_q=%h", pulses, cnt_q);

    // ---- T2: prescaler 3 -> period 4 ----
    match_en = 1'b0;
    presc_wr = 1'b1; presc_data = 16'd3;
    tick();
    cmd_start = 1'b1;
    tick();
    wait_pulse("t2_first", n);
    chk("t2_first_latency", 32'(n), 32'd4);
    wait_pulse("t2_period", n);
    chk("t2_period", 32'(n), 32'd4);
    $display("T2 prescaler 3: period=%0d", n);

    // ---- T3: wrap flag at the 99->00 pulse, cleared by start ----
    do_reset();
    cmd_start = 1'b1;
    tick();
    pulses = 0; n = 0;
    while (wrap_flag !== 1'b1 && n < 300) begin
      tick(); n++;
      if (cnt_en === 1'b1) pulses++;
    end
    chk("t3_timeout", 32'(n < 300), 32'd1);
    chk("t3_pulses", 32'(pulses), 32'd100);
    chk("t3_cnt_at_wrap", 32'(cnt_q), 32'h99);
    cmd_stop = 1'b1; tick();
    cmd_start = 1'b1; tick();
    chk("t3_wrap_cleared", 32'(wrap_flag), 32'd0);
    $display("T3 wrap after %0d pulses", pulses);

    // ---- T4: single steps, then step ignored while running ----
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cmd_step = 1'b1; tick();
      if (cnt_en === 1'b1) pulses++;
      tick();
      if (cnt_en === 1'b1) pulses++;
    end
    chk("t4_step_pulses", 32'(pulses), 32'd3);
    tick();
    chk("t4_cnt_q", 32'(cnt_q), 32'h03);
    presc_wr = 1'b1; presc_data = 16'd3; tick();
    cmd_start = 1'b1; tick();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1 || i == 4) cmd_step = 1'b1;
      tick();
      if (cnt_en === 1'b1) pulses++;
    end
    chk("t4_run_pulses", 32'(pulses), 32'd3);
    $display("T4 steps ok, run pulses=%0d", pulses);

    // ---- T5: start+stop together, non-BCD target ignored ----
    cmd_stop = 1'b1; tick();
    do_reset();
    cmd_start = 1'b1; cmd_stop = 1'b1; tick();
    chk("t5_start_stop_idle", 32'(state_o), 32'd0);
    tgt_wr = 1'b1; tgt_data = 8'h4A; match_en = 1'b1; tick();
    cmd_start = 1'b1; tick();
    n = 0;
    while (match_irq !== 1'b1 && n < 300) begin tick(); n++; end
    chk("t5_timeout", 32'(n < 300), 32'd1);
    tick();
    chk("t5_match_at_99", 32'(cnt_q), 32'h99);
    $display("T5 target kept at 99, cnt_q=%h", cnt_q);

    // ---- T6: reset mid-run at 37 ----
    match_en = 1'b0;
    do_reset();
    cmd_start = 1'b1; tick();
    n = 0;
    while (cnt_q !== 8'h37 && n < 200) begin tick(); n++; end
    chk("t6_timeout", 32'(n < 200), 32'd1);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cnt_en === 1'b1) pulses++;
    end
    chk("t6_no_pulse", 32'(pulses), 32'd0);
    $display("T6 reset mid-run, pulses after release=%0d", pulses);

    // ---- Random phase ----
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cmd_start = (r < 6);
      cmd_stop  = (r >= 5 && r < 8);
      cmd_step  = (r >= 8 && r < 14) || (r == 0);
      if ($urandom_range(0, 19) == 0) begin
        tgt_wr = 1'b1;
        if ($urandom_range(0, 3) == 0) tgt_data = 8'($urandom_range(0, 255));
        else tgt_data = to_bcd(int'($urandom_range(0, 99)));
      end
      if ($urandom_range(0, 24) == 0) begin
        presc_wr = 1'b1; presc_data = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 29) == 0) match_en = ~match_en;
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end
    $display("Random phase done: checks so far=%0d", n_chk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
